// File: rtl/fp_serial_tx.sv
// Serial output stage for the 12-bit-to-float converter: buffers packed
// {sign, exp, sig} words in a small FIFO and shifts each one out MSB-first.
module fp_serial_tx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sign,
    input  logic [2:0]       in_exp,
    input  logic [3:0]       in_sig,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_done,
    output logic [CNT_W-1:0] level,
    output logic             drop_flag
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [7:0]       shreg;
    logic [2:0]       bitcnt;
    logic             full;
    logic             push;
    logic             pop;

    // A full FIFO refuses a push even if the transmitter pops in the same cycle.
    assign full     = (level == CNT_W'(DEPTH));
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (level != '0);

    assign ser_frame = (state == SHIFT);
    assign ser_out   = (state == SHIFT) && shreg[7];
    assign ser_done  = (state == GAP);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {in_sign, in_exp, in_sig};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            level     <= '0;
            drop_flag <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (in_valid && !in_ready) begin
                drop_flag <= 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Transmitter: one IDLE cycle to pop, eight SHIFT cycles, one GAP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rptr   <= '0;
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        shreg  <= mem[rptr];
                        rptr   <= rptr + PTR_W'(1);
                        bitcnt <= 3'd7;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg  <= {shreg[6:0], 1'b0};
                    bitcnt <= bitcnt - 3'd1;
                    if (bitcnt == 3'd0) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fp_serial_tx.md
# fp_serial_tx

Output stage downstream of the 12-bit-to-floating-point converter. It captures each converted result (sign, 3-bit exponent, 4-bit significand) as an 8-bit word into a small FIFO. It then shifts each word out MSB-first on a single serial line with a frame strobe. It decouples the converter's per-cycle results from a slow serial consumer, and reports overflow when results arrive faster than they can be sent.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  converter result present this cycle.
- in_sign  input  1  sign from converter.
- in_exp  input  3  exponent from converter.
- in_sig  input  4  significand from converter.
- in_ready  output  1  FIFO can accept a word.
- ser_out  output  1  serial data, MSB first.
- ser_frame  output  1  high for the 8 cycles in which ser_out carries valid bits.
- ser_done  output  1  one-cycle pulse after the last bit of a word.
- level  output  CNT_W  current FIFO occupancy, 0..DEPTH.
- drop_flag  output  1  sticky: a word was offered while full.

## Operation
- Packing: word = {in_sign, in_exp, in_sig}; bit 7 = sign, bits 6:4 = exponent, bits 3:0 = significand.
- Push: occurs when in_valid && in_ready. in_ready = !full && !rst. This is combinational from registered state.
- Overflow: in_valid && !in_ready with rst low drops the word and sets drop_flag. drop_flag clears only on rst.
- FIFO: circular buffer with read/write pointers that wrap modulo DEPTH. level increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- A push is refused when full, even if a pop occurs the same cycle.
- Transmitter FSM:
  - IDLE: ser_frame=0, ser_out=0. If level != 0, pop the head into an 8-bit shift register, load bit count 7, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: ser_frame=1, ser_out = shreg[7]. Each cycle, shift left by 1 and decrement the count. When the count is 0, go to GAP.
  - GAP: ser_frame=0, ser_out=0, ser_done=1 for this cycle only. Then go to IDLE.
- Outputs ser_out, ser_frame and ser_done are registered or decoded directly from FSM state, with no input-to-output combinational path.
- Reset (synchronous, any state, including mid-frame):
  - FSM returns to IDLE; pointers, level and the shift register clear to 0.
  - The partially sent word is abandoned; no ser_done pulse is produced for it.
- Reset values: in_ready=0 while rst is high; ser_out=0, ser_frame=0, ser_done=0, level=0, drop_flag=0.

## Timing
- Push accepted in cycle N: level reflects it in N+1.
- The FSM in IDLE pops in N+1. ser_frame is high in cycles N+2..N+9, carrying bits 7..0 in order. ser_done is high in N+10, and the FSM is back in IDLE in N+11.
- Sustained throughput: one word per 10 cycles (IDLE, 8×SHIFT, GAP).
- Back-to-back words give exactly 2 low cycles of ser_frame between frames (GAP, IDLE).
- Storage capacity is DEPTH words in the FIFO plus 1 word in the shift register.
- Empty FIFO: the FSM stays in IDLE with no spurious frame.
- Full FIFO: in_ready goes low in the cycle after level reaches DEPTH. It rises in the cycle after the next pop.
- First cycle after rst deasserts: in_ready=1 and level=0.

## Test plan
- Single word:
  - Stimulus: push sign=1, exp=101, sig=1100 (0xDC) in cycle 0.
  - Response: ser_frame high in cycles 2..9, with ser_out = 1,1,0,1,1,1,0,0; ser_done high in cycle 10 only; level returns to 0 by cycle 2.
- Saturation code:
  - Stimulus: push 0x7F, then 0x80, back-to-back.
  - Response: bit streams 0,1,1,1,1,1,1,1 and 1,0,0,0,0,0,0,0, with exactly 2 frame-low cycles between the frames.
- Overflow:
  - Stimulus: in_valid high in cycles 0..5 with words 0x01..0x06 (DEPTH=4).
  - Response: cycle 1 has a simultaneous push and pop, so level stays 1. level reaches 4 after cycle 4. in_ready=0 in cycle 5, 0x06 is dropped and drop_flag=1. Frames 0x01..0x05 are then sent in order.
- Wrap-around:
  - Stimulus: push 10 words spaced 10 cycles apart.
  - Response: all 10 are sent in order, proving pointer wrap; level never exceeds 1; drop_flag stays 0.
- Reset mid-frame:
  - Stimulus: assert rst in cycle 5 of a frame, with 2 words queued.
  - Response: in the next cycle, ser_frame=0, ser_out=0 and level=0; no ser_done pulse; no further frames until a new push.
- Idle:
  - Stimulus: no pushes for 50 cycles after reset.
  - Response: ser_frame=0, ser_done=0, in_ready=1 and level=0 throughout.
